wb_uart_rx_cfg: RTL

Parametrised UART receiver with a Wishbone pop interface. It supports configurable data width, parity and stop bits, and samples each bit at mid-point after start-bit validation. Every received word is stored in an internal FIFO together with per-word framing and parity error flags. It is the next-generation RX peripheral for the Z80 system bus bridge, and has an overrun flag and a FIFO fill level.

---
 rtl/wb_uart_rx_cfg_if.sv | 27 ++
 rtl/wb_uart_rx_cfg.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_uart_rx_cfg_if.sv
// Wishbone pop port of the UART receiver: classic cycle/strobe request with
// stall back-pressure and a single-cycle acknowledge carrying the popped word.
interface wb_uart_rx_cfg_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic                   i_wb_cyc;
  logic                   i_wb_stb;
  logic [DATA_BITS+1:0]   o_wb_data;
  logic                   o_wb_ack;
  logic                   o_wb_stall;

  modport master (
    output i_wb_cyc,
    output i_wb_stb,
    input  o_wb_data,
    input  o_wb_ack,
    input  o_wb_stall
  );

  modport slave (
    input  i_wb_cyc,
    input  i_wb_stb,
    output o_wb_data,
    output o_wb_ack,
    output o_wb_stall
  );
endinterface

// File: rtl/wb_uart_rx_cfg.sv
// Parametrised UART receiver (mid-bit sampling, optional parity, 1/2 stop bits)
// feeding a word FIFO with per-word error flags, popped over Wishbone.
module wb_uart_rx_cfg #(
  parameter int unsigned CLKS_PER_BIT = 2604,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_AW      = 4
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  wb_uart_rx_cfg_if.slave    wb,
  input  logic               uart_rx,
  output logic               uart_empty,
  output logic [FIFO_AW:0]   o_fifo_count,
  output logic               o_overrun,
  input  logic               i_clear_overrun
);

  localparam int unsigned CW     = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int unsigned WW     = DATA_BITS + 2;
  localparam int unsigned DEPTH  = 2 ** FIFO_AW;

  localparam logic [CW-1:0] CNT_FULL  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic          ODD       = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_PUSH
  } state_t;

  state_t                state;
  logic                  rx_meta;
  logic                  rx_s;
  logic                  armed;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         bit_idx;
  logic                  stop_idx;
  logic [DATA_BITS-1:0]  shreg;
  logic                  par_err;
  logic                  frm_err;

  logic [WW-1:0]         mem [DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr;
  logic [FIFO_AW-1:0]    rd_ptr;
  logic [FIFO_AW:0]      count_q;
  logic [FIFO_AW:0]      count_nxt;
  logic                  empty_q;
  logic                  ack_q;
  logic [WW-1:0]         data_q;
  logic                  ovr_q;

  logic                  pop_acc;
  logic                  push_req;
  logic                  full;
  logic                  do_push;
  logic                  ovr_set;
  logic [WW-1:0]         push_word;

  // Two-flop synchroniser; idles high like the line itself.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame receiver: every sample point is reached when cnt hits zero.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= S_IDLE;
      armed    <= 1'b0;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state <= S_START;
            cnt   <= CNT_HALF;
          end
        end
        S_START: begin
          if (cnt == '0) begin
            if (!rx_s) begin
              state    <= S_DATA;
              cnt      <= CNT_FULL;
              bit_idx  <= '0;
              stop_idx <= 1'b0;
              par_err  <= 1'b0;
              frm_err  <= 1'b0;
            end else begin
              state <= S_IDLE;
              armed <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == '0) begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            cnt   <= CNT_FULL;
            if (bit_idx == BIT_LAST) begin
              if (PARITY != 0) state <= S_PARITY;
              else             state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_PARITY: begin
          if (cnt == '0) begin
            par_err <= ((^shreg) ^ rx_s) != ODD;
            cnt     <= CNT_FULL;
            state   <= S_STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == '0) begin
            if (!rx_s) frm_err <= 1'b1;
            if (stop_idx == STOP_LAST) begin
              state <= S_PUSH;
            end else begin
              stop_idx <= 1'b1;
              cnt      <= CNT_FULL;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_PUSH: begin
          state <= S_IDLE;
          armed <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          armed <= 1'b0;
        end
      endcase
    end
  end

  assign push_word = {par_err, frm_err, shreg};
  assign push_req  = (state == S_PUSH);
  assign pop_acc   = wb.i_wb_cyc && wb.i_wb_stb && !empty_q;
  assign full      = (count_q == (FIFO_AW + 1)'(DEPTH));
  // A pop in the same cycle frees the slot the incoming word needs.
  assign do_push   = push_req && (!full || pop_acc);
  assign ovr_set   = push_req && full && !pop_acc;

  always_comb begin
    count_nxt = count_q;
    if (do_push && !pop_acc)      count_nxt = count_q + 1'b1;
    else if (!do_push && pop_acc) count_nxt = count_q - 1'b1;
  end

  // Storage array carries no reset; validity is tracked by the pointers.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      ack_q   <= 1'b0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      count_q <= count_nxt;
      empty_q <= (count_nxt == '0);
      ack_q   <= pop_acc;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
        data_q <= mem[rd_ptr];
      end
      if (ovr_set)              ovr_q <= 1'b1;
      else if (i_clear_overrun) ovr_q <= 1'b0;
    end
  end

  assign wb.o_wb_data  = data_q;
  assign wb.o_wb_ack   = ack_q;
  assign wb.o_wb_stall = empty_q;
  assign uart_empty    = empty_q;
  assign o_fifo_count  = count_q;
  assign o_overrun     = ovr_q;

endmodule
